// File: rtl/cover_toggle_collector_pkg.sv
// Shared types and helpers for the toggle-cover collector.
package cover_pkg;
   localparam int COVER_IDX_W = 64;
   localparam int POP_MAX_W   = 1024;

   typedef logic [COVER_IDX_W-1:0] cover_idx_t;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

   // Callers zero-extend their vector to POP_MAX_W; 11 bits hold a count of 1024.
   function automatic logic [10:0] popcount(input logic [POP_MAX_W-1:0] v);
      logic [10:0] n;
      n = '0;
      for (int i = 0; i < POP_MAX_W; i++) n = n + 11'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/cover_toggle_collector_if.sv
// Valid/ready stream of global cover indices.
interface cover_toggle_collector_if;
   import cover_pkg::*;
   logic       out_valid;
   logic       out_ready;
   cover_idx_t out_index;

   modport master (output out_valid, output out_index, input out_ready);
   modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/cover_toggle_collector_prio_enc.sv
// Combinational lowest-set-bit finder.
module cover_prio_enc #(
   parameter  int WIDTH = 120,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] in,
   output logic [IDX_W-1:0] idx,
   output logic             found
);
   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (in[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-cover bitmap; streams each first hit once as a global index.
module cover_toggle_collector
   import cover_pkg::*;
#(
   parameter  int WIDTH       = 120,
   parameter  int COVER_INDEX = 0,
   parameter  int COVER_TOTAL = 28338,
   localparam int CNT_W       = $clog2(WIDTH + 1)
) (
   input  logic                       gbl_clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           valid,
   input  logic                       en,
   input  logic                       clear,
   cover_toggle_collector_if.master   out_if,
   output logic [CNT_W-1:0]           hit_count,
   output logic                       all_hit
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   generate
      if (WIDTH < 1 || WIDTH > POP_MAX_W || COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_cfg
         $error("cover_toggle_collector: group range exceeds COVER_TOTAL or bad WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] hit, pending, new_hits, load_mask;
   logic [IDX_W-1:0] lo_idx;
   logic             lo_found;
   logic             load;
   out_state_t       state, state_nxt;
   cover_idx_t       idx_r;
   logic [CNT_W-1:0] cnt;

   cover_prio_enc #(.WIDTH(WIDTH)) u_prio (
      .in    (pending),
      .idx   (lo_idx),
      .found (lo_found)
   );

   assign new_hits  = (en && !clear) ? (valid & ~hit) : '0;
   assign load_mask = load ? (WIDTH'(1) << lo_idx) : '0;

   // Clear wipes pending, so no load is taken in a clear cycle; a held beat still completes.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         EMPTY: if (lo_found && !clear) begin
            load      = 1'b1;
            state_nxt = FULL;
         end
         FULL: if (out_if.out_ready) begin
            if (lo_found && !clear) load = 1'b1;
            else                    state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge gbl_clk) begin
      if (!reset) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_ff @(posedge gbl_clk) begin
      if (!reset) begin
         hit     <= '0;
         pending <= '0;
         cnt     <= '0;
         idx_r   <= '0;
      end else begin
         if (clear) begin
            hit     <= '0;
            pending <= '0;
            cnt     <= '0;
         end else begin
            hit     <= hit | new_hits;
            pending <= (pending & ~load_mask) | new_hits;
            cnt     <= cnt + CNT_W'(popcount(POP_MAX_W'(new_hits)));
         end
         if (load) idx_r <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(lo_idx);
      end
   end

   assign out_if.out_valid = (state == FULL);
   assign out_if.out_index = idx_r;
   assign hit_count        = cnt;
   assign all_hit          = (cnt == CNT_W'(WIDTH));
endmodule
